// File: rtl/picorv32_axi_pkg.sv
// Shared definitions for the native-memory to AXI4-Lite bridge.
// Holds the bridge state encoding, the AXI response codes, the AXI
// protection encodings for instruction and data accesses, and a helper
// that classifies a response code as an error.
package picorv32_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } axi_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_INSN = 3'b100;
    localparam logic [2:0] PROT_DATA = 3'b000;

    // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/picorv32_mem_axi_master_if.sv
// Bus bundle for the bridge: the core's native memory bus on one side and
// the AXI4-Lite master channels on the other.
//   master modport : the bridge (consumes native requests, drives AXI master)
//   slave  modport : the environment (issues native requests, acts as AXI slave)
interface picorv32_mem_axi_master_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    modport master (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        output m_axi_rready
    );

    modport slave (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        input  m_axi_rready
    );

endinterface

// File: rtl/picorv32_mem_axi_master.sv
// Native memory bus to AXI4-Lite master bridge, one transaction at a time.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : native request side + AXI master channels (master modport)
//   bus_error   : pulse with mem_ready when the response was SLVERR/DECERR
//   err_addr    : address of the first errored transaction since last clear
//   err_valid   : sticky flag qualifying err_addr
//   err_clear   : clears err_valid, dominates a same-cycle capture
// Every output comes straight from a register; AXI inputs only feed the
// next-state logic, so there is no input-to-output combinational path.
module picorv32_mem_axi_master
    import picorv32_axi_pkg::*;
(
    input  logic                             clk,
    input  logic                             resetn,
    picorv32_mem_axi_master_if.master        bus,
    output logic                             bus_error,
    output logic [31:0]                      err_addr,
    output logic                             err_valid,
    input  logic                             err_clear
);

    axi_state_e  r_state;
    axi_state_e  w_nxt_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_prot;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;
    logic [31:0] r_err_addr;
    logic        r_err_valid;
    logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic        r_mem_ready, r_bus_error;

    logic        w_nxt_awvalid, w_nxt_wvalid, w_nxt_bready;
    logic        w_nxt_arvalid, w_nxt_rready;
    logic        w_nxt_mem_ready, w_nxt_bus_error;
    logic        w_capture, w_load_resp, w_load_rdata, w_err_hit;
    logic [1:0]  w_resp;

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_awvalid   = r_awvalid;
        w_nxt_wvalid    = r_wvalid;
        w_nxt_bready    = 1'b0;
        w_nxt_arvalid   = r_arvalid;
        w_nxt_rready    = 1'b0;
        w_nxt_mem_ready = 1'b0;
        w_nxt_bus_error = 1'b0;
        w_capture       = 1'b0;
        w_load_resp     = 1'b0;
        w_load_rdata    = 1'b0;
        w_resp          = r_resp;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    w_capture = 1'b1;
                    if (bus.mem_wstrb != 4'b0000) begin
                        w_nxt_state   = ST_WR_REQ;
                        w_nxt_awvalid = 1'b1;
                        w_nxt_wvalid  = 1'b1;
                    end else begin
                        w_nxt_state   = ST_RD_REQ;
                        w_nxt_arvalid = 1'b1;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // A low valid means that channel already handshook, so the
                // two channels may complete in either order or together.
                w_nxt_awvalid = r_awvalid & ~bus.m_axi_awready;
                w_nxt_wvalid  = r_wvalid & ~bus.m_axi_wready;
                if (!w_nxt_awvalid && !w_nxt_wvalid) begin
                    w_nxt_state  = ST_WR_RESP;
                    w_nxt_bready = 1'b1;
                end else begin
                    w_nxt_state  = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (bus.m_axi_bvalid) begin
                    w_nxt_state     = ST_DONE;
                    w_nxt_mem_ready = 1'b1;
                    w_nxt_bus_error = resp_is_error(bus.m_axi_bresp);
                    w_resp          = bus.m_axi_bresp;
                    w_load_resp     = 1'b1;
                end else begin
                    w_nxt_bready    = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (bus.m_axi_arready) begin
                    w_nxt_state   = ST_RD_RESP;
                    w_nxt_arvalid = 1'b0;
                    w_nxt_rready  = 1'b1;
                end else begin
                    w_nxt_arvalid = 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (bus.m_axi_rvalid) begin
                    w_nxt_state     = ST_DONE;
                    w_nxt_mem_ready = 1'b1;
                    w_nxt_bus_error = resp_is_error(bus.m_axi_rresp);
                    w_resp          = bus.m_axi_rresp;
                    w_load_resp     = 1'b1;
                    w_load_rdata    = 1'b1;
                end else begin
                    w_nxt_rready    = 1'b1;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state   = ST_IDLE;
                w_nxt_awvalid = 1'b0;
                w_nxt_wvalid  = 1'b0;
                w_nxt_arvalid = 1'b0;
            end
        endcase
        // The latched response is examined during DONE, so err_* follow
        // mem_ready by one cycle.
        w_err_hit = (r_state == ST_DONE) && resp_is_error(r_resp) && !r_err_valid;
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_awvalid   <= w_nxt_awvalid;
            r_wvalid    <= w_nxt_wvalid;
            r_bready    <= w_nxt_bready;
            r_arvalid   <= w_nxt_arvalid;
            r_rready    <= w_nxt_rready;
            r_mem_ready <= w_nxt_mem_ready;
            r_bus_error <= w_nxt_bus_error;
        end
    end

    // Request capture; these registers drive the AXI address/data outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_wstrb <= 4'b0000;
            r_prot  <= PROT_DATA;
        end else if (w_capture) begin
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wdata;
            r_wstrb <= bus.mem_wstrb;
            r_prot  <= bus.mem_instr ? PROT_INSN : PROT_DATA;
        end
    end

    // Response code and read data latches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp  <= AXI_RESP_OKAY;
            r_rdata <= 32'h0000_0000;
        end else begin
            if (w_load_resp) begin
                r_resp <= w_resp;
            end
            if (w_load_rdata) begin
                r_rdata <= bus.m_axi_rdata;
            end
        end
    end

    // Sticky first-error capture; a clear dominates a simultaneous capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= 32'h0000_0000;
        end else if (err_clear) begin
            r_err_valid <= 1'b0;
        end else if (w_err_hit) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
        end
    end

    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_awprot  = r_prot;
    assign bus.m_axi_wvalid  = r_wvalid;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wstrb   = r_wstrb;
    assign bus.m_axi_bready  = r_bready;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arprot  = r_prot;
    assign bus.m_axi_rready  = r_rready;
    assign bus.mem_ready     = r_mem_ready;
    assign bus.mem_rdata     = r_rdata;
    assign bus_error         = r_bus_error;
    assign err_addr          = r_err_addr;
    assign err_valid         = r_err_valid;

endmodule

// File: tb/tb_picorv32_mem_axi_master.sv
// Self-checking bench for picorv32_mem_axi_master. The bench plays both the
// core and a scheduled AXI slave. For each transaction the expected cycle of
// every valid/ready/mem_ready is derived from the slave delays with plain
// arithmetic; outputs are compared on every falling edge.
`timescale 1ns/1ps
module tb_picorv32_mem_axi_master;
    import picorv32_axi_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        err_clear = 1'b0;
    logic        bus_error;
    logic [31:0] err_addr;
    logic        err_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [31:0] m_rdata = 32'h0;
    logic        m_err_valid = 1'b0;
    logic [31:0] m_err_addr = 32'h0;
    int          last_ready_k;

    picorv32_mem_axi_master_if bus ();

    picorv32_mem_axi_master dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .bus_error (bus_error),
        .err_addr  (err_addr),
        .err_valid (err_valid),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic slave_quiet();
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = 32'h0;
        bus.m_axi_rresp   = 2'b00;
    endtask

    // Called on a falling edge (N0). a/w: AW and W ready delays (for reads a
    // is the AR delay); b: B or R valid delay. Returns on falling edge done+1.
    task automatic run_txn(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic instr, input int a, input int w,
                           input int b, input logic [31:0] rdata, input logic [1:0] resp,
                           input logic clr_at_done);
        int          last;
        int          done;
        logic [2:0]  prot;
        logic        exp_aw, exp_w, exp_ar;
        prot = instr ? PROT_INSN : PROT_DATA;
        last = (is_wr ? ((a > w) ? a : w) : a) + 1;  // edge of the final request handshake
        done = last + 2 + b;                         // falling edge where mem_ready is seen
        last_ready_k = -1;
        slave_quiet();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = is_wr ? strb : 4'b0000;
        bus.mem_instr = instr;
        for (int k = 1; k <= done + 1; k++) begin
            @(negedge clk);
            bus.m_axi_awready = is_wr && (k == a + 1);
            bus.m_axi_wready  = is_wr && (k == w + 1);
            bus.m_axi_bvalid  = is_wr && (k == last + 1 + b);
            bus.m_axi_bresp   = bus.m_axi_bvalid ? resp : ~resp;
            bus.m_axi_arready = !is_wr && (k == a + 1);
            bus.m_axi_rvalid  = !is_wr && (k == last + 1 + b);
            bus.m_axi_rdata   = bus.m_axi_rvalid ? rdata : ~rdata;
            bus.m_axi_rresp   = bus.m_axi_rvalid ? resp : ~resp;
            err_clear = clr_at_done && (k == done);
            if (k == done) begin
                bus.mem_valid = 1'b0;
                if (!is_wr) m_rdata = rdata;
            end
            exp_aw = is_wr && (k <= a + 1);
            exp_w  = is_wr && (k <= w + 1);
            exp_ar = !is_wr && (k <= a + 1);
            chk("awvalid", {31'b0, bus.m_axi_awvalid}, {31'b0, exp_aw});
            chk("wvalid", {31'b0, bus.m_axi_wvalid}, {31'b0, exp_w});
            chk("arvalid", {31'b0, bus.m_axi_arvalid}, {31'b0, exp_ar});
            chk("bready", {31'b0, bus.m_axi_bready}, {31'b0, is_wr && k >= last + 1 && k < done});
            chk("rready", {31'b0, bus.m_axi_rready}, {31'b0, !is_wr && k >= last + 1 && k < done});
            chk("mem_ready", {31'b0, bus.mem_ready}, {31'b0, k == done});
            chk("bus_error", {31'b0, bus_error}, {31'b0, (k == done) && resp[1]});
            chk("mem_rdata", bus.mem_rdata, m_rdata);
            chk("err_valid", {31'b0, err_valid}, {31'b0, m_err_valid});
            if (m_err_valid) chk("err_addr", err_addr, m_err_addr);
            if (exp_aw) begin
                chk("awaddr", bus.m_axi_awaddr, addr);
                chk("awprot", {29'b0, bus.m_axi_awprot}, {29'b0, prot});
            end
            if (exp_w) begin
                chk("wdata", bus.m_axi_wdata, wdata);
                chk("wstrb", {28'b0, bus.m_axi_wstrb}, {28'b0, strb});
            end
            if (exp_ar) begin
                chk("araddr", bus.m_axi_araddr, addr);
                chk("arprot", {29'b0, bus.m_axi_arprot}, {29'b0, prot});
            end
            if (bus.mem_ready) last_ready_k = k;
            // Error capture is visible one cycle after mem_ready.
            if (k == done && resp[1] && !m_err_valid && !clr_at_done) begin
                m_err_valid = 1'b1;
                m_err_addr  = addr;
            end
            if (k == done && clr_at_done) m_err_valid = 1'b0;
        end
        err_clear = 1'b0;
        slave_quiet();
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_err_valid = 1'b0;
        chk("err_clear", {31'b0, err_valid}, 32'd0);
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'b0000;
        slave_quiet();

        // Reset state
        @(negedge clk);
        chk("rst_awvalid", {31'b0, bus.m_axi_awvalid}, 32'd0);
        chk("rst_wvalid", {31'b0, bus.m_axi_wvalid}, 32'd0);
        chk("rst_arvalid", {31'b0, bus.m_axi_arvalid}, 32'd0);
        chk("rst_bready", {31'b0, bus.m_axi_bready}, 32'd0);
        chk("rst_rready", {31'b0, bus.m_axi_rready}, 32'd0);
        chk("rst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_awaddr", bus.m_axi_awaddr, 32'd0);
        chk("rst_araddr", bus.m_axi_araddr, 32'd0);
        chk("rst_wdata", bus.m_axi_wdata, 32'd0);
        chk("rst_wstrb", {28'b0, bus.m_axi_wstrb}, 32'd0);
        chk("rst_prot", {26'b0, bus.m_axi_awprot, bus.m_axi_arprot}, 32'd0);
        chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        resetn = 1'b1;

        // Zero-wait instruction read
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b1, 0, 0, 0, 32'hDEAD_BEEF, AXI_RESP_OKAY, 1'b0);
        chk("rd0_latency", last_ready_k, 32'd3);
        chk("rd0_rdata", bus.mem_rdata, 32'hDEAD_BEEF);

        // Write with wready lagging awready by 4 cycles
        run_txn(1'b1, 32'h0000_0204, 32'h0000_AB00, 4'b0010, 1'b0, 0, 4, 0, 32'h0, AXI_RESP_OKAY, 1'b0);
        chk("wr_lag_latency", last_ready_k, 32'd7);
        chk("wr_rdata_kept", bus.mem_rdata, 32'hDEAD_BEEF);

        // W before AW, with a delayed B
        run_txn(1'b1, 32'h0000_0208, 32'h1122_3344, 4'b1111, 1'b0, 3, 1, 2, 32'h0, AXI_RESP_EXOKAY, 1'b0);
        chk("wr_order_latency", last_ready_k, 32'd8);

        // Two errored writes: first address sticks
        run_txn(1'b1, 32'h8000_0000, 32'h5555_AAAA, 4'b1111, 1'b0, 0, 0, 0, 32'h0, AXI_RESP_SLVERR, 1'b0);
        chk("err1_addr", err_addr, 32'h8000_0000);
        chk("err1_valid", {31'b0, err_valid}, 32'd1);
        run_txn(1'b1, 32'h9000_0000, 32'h0, 4'b0001, 1'b0, 0, 0, 0, 32'h0, AXI_RESP_DECERR, 1'b0);
        chk("err2_addr_kept", err_addr, 32'h8000_0000);
        pulse_clear();

        // Clear coincident with a capture opportunity wins
        run_txn(1'b1, 32'h0000_00A0, 32'h0, 4'b1000, 1'b0, 0, 0, 0, 32'h0, AXI_RESP_SLVERR, 1'b1);
        chk("clr_wins", {31'b0, err_valid}, 32'd0);

        // Read with AR stalled 5 cycles and R delayed 3 cycles
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'b0000, 1'b0, 5, 0, 3, 32'hCAFE_F00D, AXI_RESP_OKAY, 1'b0);
        chk("rd_stall_latency", last_ready_k, 32'd11);
        chk("rd_stall_rdata", bus.mem_rdata, 32'hCAFE_F00D);

        // Errored read captures after the clear
        run_txn(1'b0, 32'h0000_0400, 32'h0, 4'b0000, 1'b1, 1, 0, 0, 32'h0BAD_0BAD, AXI_RESP_DECERR, 1'b0);
        chk("rd_err_addr", err_addr, 32'h0000_0400);

        // Asynchronous reset while in WR_REQ
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0600;
        bus.mem_wdata = 32'hFFFF_0000;
        bus.mem_wstrb = 4'b1111;
        bus.mem_instr = 1'b0;
        @(negedge clk);
        chk("pre_rst_awvalid", {31'b0, bus.m_axi_awvalid}, 32'd1);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("async_awvalid", {31'b0, bus.m_axi_awvalid}, 32'd0);
        chk("async_wvalid", {31'b0, bus.m_axi_wvalid}, 32'd0);
        chk("async_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("async_err_valid", {31'b0, err_valid}, 32'd0);
        chk("async_awaddr", bus.m_axi_awaddr, 32'd0);
        bus.mem_valid = 1'b0;
        m_rdata = 32'h0;
        m_err_valid = 1'b0;
        m_err_addr = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        run_txn(1'b0, 32'h0000_0500, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h0F0F_1234, AXI_RESP_OKAY, 1'b0);
        chk("post_rst_latency", last_ready_k, 32'd3);
        chk("post_rst_rdata", bus.mem_rdata, 32'h0F0F_1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_axi_master.md
# picorv32_mem_axi_master

Bridges the core's native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_instr, driven by picorv32_memory_interface) onto an AXI4-Lite master port. It sits directly downstream of the memory interface and serves one transaction at a time: each native request becomes one AXI read or write. It returns read data and a single-cycle mem_ready, and reports slave error responses.

## Interface
Parameters:
- none. Widths are fixed: 32-bit address, 32-bit data, 4-bit strobe.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- resetn  in  1  reset: asynchronous, active-low
- mem_valid  in  1  native request valid; held until mem_ready is seen
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  word-aligned byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 means read, nonzero means write
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data; registered, held until the next read completes
- m_axi_awvalid / m_axi_awready  out / in  1  write address handshake
- m_axi_awaddr / m_axi_awprot  out  32 / 3  write address and protection
- m_axi_wvalid / m_axi_wready  out / in  1  write data handshake
- m_axi_wdata / m_axi_wstrb  out  32 / 4  write data and strobes
- m_axi_bvalid / m_axi_bready  in / out  1  write response handshake
- m_axi_bresp  in  2  write response code
- m_axi_arvalid / m_axi_arready  out / in  1  read address handshake
- m_axi_araddr / m_axi_arprot  out  32 / 3  read address and protection
- m_axi_rvalid / m_axi_rready  in / out  1  read data handshake
- m_axi_rdata / m_axi_rresp  in  32 / 2  read data and response code
- bus_error  out  1  pulse coincident with mem_ready when the captured response has bit[1] set (SLVERR or DECERR)
- err_addr  out  32  address of the first errored transaction since the last clear
- err_valid  out  1  sticky: err_addr holds a captured address
- err_clear  in  1  clears err_valid; err_clear wins over a same-cycle capture

## Operation
State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: when mem_valid=1, capture addr, wdata, wstrb and prot.
  - prot = 3'b100 if mem_instr=1, else 3'b000.
  - Go to WR_REQ if wstrb≠0, else RD_REQ.
- WR_REQ: awvalid and wvalid are raised together.
  - Each one drops independently after its own handshake.
  - Advance to WR_RESP once both handshakes have completed, whether in the same cycle or in any order.
- WR_RESP: bready=1. On bvalid, latch bresp and go to DONE.
- RD_REQ: arvalid=1 until arready. Then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, register rdata into mem_rdata, latch rresp, and go to DONE.
- DONE: mem_ready=1 for exactly one cycle, with bus_error as defined in Interface. Return to IDLE.
  - The upstream block drops mem_valid on the same edge, so IDLE never re-accepts a completed request.
- Error capture: an errored response loads err_addr and sets err_valid only while err_valid=0.
- Address and data outputs are stable, straight from the capture registers, while the corresponding valid is high.

## Timing
- Reset values: all valid and ready outputs 0, mem_ready 0, bus_error 0, mem_rdata 0, all AXI address/data/strobe/prot outputs 0, err_addr 0, err_valid 0, state IDLE.
- Zero-wait slave, mem_valid sampled at edge 0:
  - AXI valid(s) high after edge 0.
  - bready/rready high after edge 1.
  - mem_ready high after edge 2.
  - 3 cycles per transaction, with no back-to-back overlap.
- Slave stalls extend the corresponding state without limit. There is no timeout.
- Outputs are purely registered. There are no combinational paths from AXI inputs to AXI outputs or to mem_ready.
- Reset mid-transaction: all outputs clear immediately (asynchronous reset). The in-flight AXI transaction is abandoned; the slave must be reset alongside.

## Structure
- Shared package picorv32_axi_pkg holds:
  - state encoding constants;
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - PROT_INSN = 3'b100 and PROT_DATA = 3'b000.
- Single module; no sub-module is needed.

## Test plan
- Read 0x0000_0100, instr=1, zero-wait slave returning 0xDEADBEEF/OKAY -> arprot=100, mem_ready 3 cycles after request, mem_rdata=0xDEADBEEF, bus_error=0.
- Write 0x0000_0204, wdata 0x0000_AB00, wstrb 0010; wready lags awready by 4 cycles -> awvalid drops after its handshake, wvalid holds until wready, one mem_ready after bvalid.
- Write receives bresp=SLVERR at 0x8000_0000, then a second error at 0x9000_0000 -> bus_error pulses both times; err_addr stays 0x8000_0000 and err_valid=1. Pulse err_clear -> err_valid=0.
- Read with arready delayed 5 cycles and rvalid delayed 3 cycles -> arvalid held stable for 5 cycles; mem_ready exactly one cycle; mem_rdata unchanged until that cycle.
- Assert resetn=0 while in WR_REQ -> awvalid, wvalid and mem_ready go to 0 without a clock edge. After release, state is IDLE and a new read completes normally.
